// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative restoring unsigned divider that produces one quotient bit per clock.
// Each iteration does a trial subtraction (add of the inverted divisor with a
// carry-in of 1) and keeps the shifted partial remainder when the trial borrows.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request; sampled only while idle
//   dividend     unsigned dividend, captured when start is accepted
//   divisor      unsigned divisor, captured when start is accepted
//   busy         high while an operation is running or completing
//   done         one-cycle completion strobe
//   quotient     result, held until the next completion
//   remainder    result, held until the next completion
//   div_by_zero  set when the last completed operation had a zero divisor
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_d;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] w_divisor_d;
    // Partial remainder is always below the divisor, so its extra top bit is
    // provably zero between iterations and is not stored.
    logic [WIDTH-1:0] r_rem_acc;
    logic [WIDTH-1:0] w_rem_acc_d;
    logic [WIDTH-1:0] r_quo_sh;
    logic [WIDTH-1:0] w_quo_sh_d;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_d;
    logic [WIDTH-1:0] w_quotient_d;
    logic [WIDTH-1:0] w_remainder_d;
    logic             w_dbz_d;
    logic             w_busy_d;
    logic             w_done_d;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;

    // Trial subtraction: shifted - divisor as shifted + ~divisor + 1.
    assign w_shifted = {r_rem_acc, r_quo_sh[WIDTH-1]};
    assign w_trial   = w_shifted + ~{1'b0, r_divisor} + (WIDTH+1)'(1);
    assign w_borrow  = w_trial[WIDTH];

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_divisor   <= '0;
            r_rem_acc   <= '0;
            r_quo_sh    <= '0;
            r_count     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_divisor   <= w_divisor_d;
            r_rem_acc   <= w_rem_acc_d;
            r_quo_sh    <= w_quo_sh_d;
            r_count     <= w_count_d;
            quotient    <= w_quotient_d;
            remainder   <= w_remainder_d;
            div_by_zero <= w_dbz_d;
            busy        <= w_busy_d;
            done        <= w_done_d;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        w_state_d     = r_state;
        w_divisor_d   = r_divisor;
        w_rem_acc_d   = r_rem_acc;
        w_quo_sh_d    = r_quo_sh;
        w_count_d     = r_count;
        w_quotient_d  = quotient;
        w_remainder_d = remainder;
        w_dbz_d       = div_by_zero;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // Zero divisor completes immediately with saturated quotient.
                        w_state_d     = S_DONE;
                        w_quotient_d  = '1;
                        w_remainder_d = dividend;
                        w_dbz_d       = 1'b1;
                    end else begin
                        w_state_d   = S_RUN;
                        w_divisor_d = divisor;
                        w_rem_acc_d = '0;
                        w_quo_sh_d  = dividend;
                        w_count_d   = '0;
                    end
                end
            end

            S_RUN: begin
                w_count_d = r_count + CNT_W'(1);
                if (!w_borrow) begin
                    w_rem_acc_d = w_trial[WIDTH-1:0];
                end else begin
                    w_rem_acc_d = w_shifted[WIDTH-1:0];
                end
                // Dividend bits shift out the top while quotient bits enter the bottom.
                w_quo_sh_d = {r_quo_sh[WIDTH-2:0], ~w_borrow};
                if (r_count == CNT_W'(WIDTH - 1)) begin
                    w_state_d     = S_DONE;
                    w_quotient_d  = w_quo_sh_d;
                    w_remainder_d = w_rem_acc_d;
                    w_dbz_d       = 1'b0;
                end
            end

            S_DONE: begin
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != S_IDLE);
        w_done_d = (w_state_d == S_DONE);
    end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH=4). A transaction-level model
// tracks acceptance, latency and expected results with plain division; a
// negedge compare process checks every output each cycle, and directed
// scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: edges since acceptance, latency, captured operands.
    bit           m_busy = 1'b0;
    int           m_cnt  = 0;
    int           m_lat  = 0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    logic [W-1:0] e_q    = '0;
    logic [W-1:0] e_r    = '0;
    logic         e_z    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_lat  <= 0;
            m_a    <= '0;
            m_b    <= '0;
            e_q    <= '0;
            e_r    <= '0;
            e_z    <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_a    <= dividend;
                m_b    <= divisor;
                m_lat  <= (divisor == '0) ? 0 : int'(W);
                if (divisor == '0) begin
                    e_q <= '1;
                    e_r <= dividend;
                    e_z <= 1'b1;
                end
            end
        end else if (m_cnt == m_lat) begin
            m_busy <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) begin
                e_q <= m_a / m_b;
                e_r <= m_a % m_b;
                e_z <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic e_done;
        e_done = m_busy && (m_cnt == m_lat);
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(e_done));
        check("quotient", 32'(quotient), 32'(e_q));
        check("remainder", 32'(remainder), 32'(e_r));
        check("div_by_zero", 32'(div_by_zero), 32'(e_z));
        if (e_done && m_b != '0) begin
            check("invariant q*b+r", 32'(quotient) * 32'(m_b) + 32'(remainder), 32'(m_a));
            check("invariant r<b", 32'(remainder < m_b), 32'(1));
        end
    end

    // One operation with literal expectations; operands are scrambled once accepted.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez, input string tag);
        int cyc;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        check({tag, " busy after accept"}, 32'(busy), 32'(1));
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            dividend = W'($urandom);
            divisor  = W'($urandom);
        end
        check({tag, " latency"}, 32'(cyc), (b == '0) ? 32'(0) : 32'(W));
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int nd;
        int last;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'(0));
        check("reset done", 32'(done), 32'(0));
        check("reset quotient", 32'(quotient), 32'(0));
        check("reset remainder", 32'(remainder), 32'(0));
        check("reset div_by_zero", 32'(div_by_zero), 32'(0));
        rst = 1'b0;

        // Basic operation and boundaries.
        run_op(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, "13/4");
        run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, "15/1");
        run_op(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, "15/15");
        run_op(4'd5, 4'd7, 4'd0, 4'd5, 1'b0, "5/7");
        run_op(4'd0, 4'd3, 4'd0, 4'd0, 1'b0, "0/3");

        // Divide by zero, then a normal op clears the flag.
        run_op(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, "9/0");
        run_op(4'd8, 4'd2, 4'd4, 4'd0, 1'b0, "8/2");

        // Exhaustive sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(W'(a), W'(b), W'(a / b), W'(a % b), 1'b0, "sweep");
            end
        end

        // Start pulses during RUN and DONE are ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd11;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        nd    = 0;
        for (int i = 0; i < int'(W) + 5; i++) begin
            if (done === 1'b1) begin
                nd++;
                check("ignored-start quotient", 32'(quotient), 32'(3));
                check("ignored-start remainder", 32'(remainder), 32'(2));
            end
            if (i == 1) begin
                start    = 1'b1;
                dividend = 4'd2;
                divisor  = 4'd0;
            end else if (i == 2) begin
                start = 1'b0;
            end else if (i == int'(W)) begin
                start = 1'b1;
            end else if (i == int'(W) + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("ignored-start done count", 32'(nd), 32'(1));

        // Asynchronous reset mid-RUN abandons the op.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 32'(0));
        check("async rst done", 32'(done), 32'(0));
        check("async rst quotient", 32'(quotient), 32'(0));
        check("async rst remainder", 32'(remainder), 32'(0));
        check("async rst div_by_zero", 32'(div_by_zero), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int i = 0; i < int'(W) + 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("no done after reset", 32'(nd), 32'(0));
        run_op(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, "12/5");

        // start held high: a new op on every return to idle.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        nd       = 0;
        last     = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                nd++;
                check("held quotient", 32'(quotient), 32'(4));
                check("held remainder", 32'(remainder), 32'(2));
                if (last >= 0) check("held spacing", 32'(i - last), 32'(W + 2));
                last = i;
            end
        end
        check("held done count", 32'(nd), 32'(3));
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
